// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between the fetch stage
//   (instruction read) and the memory stage (load/store). One requester
//   is granted at a time. The memory is then driven for LATENCY cycles, and
//   a one-cycle response pulse returns the result. Data beats fetch
//   because the memory stage holds the older instruction.
//
// Parameters
//   LATENCY       memory cycles per access (>=1)
//   STARVE_LIMIT  consecutive data grants tolerated while fetch waits
//
// Build option
//   MEM_ARB_STARVE_GUARD_EN  when defined, fetch wins the next grant after
//                            STARVE_LIMIT data grants made while it waited.
//                            When undefined, data priority is strict.
//
// Ports
//   clk, R                     clock, synchronous active-high reset
//   if_req/if_addr/if_flush    fetch request, address, branch cancel
//   if_gnt/if_rvalid/if_rdata  fetch grant pulse, data-valid pulse, data
//   d_req/d_we/d_addr/d_mode/d_wdata  data request and its fields
//   d_gnt/d_rvalid/d_rdata     data grant pulse, done pulse, load data
//   mem_en/mem_we/mem_addr/mem_mode/mem_wdata  memory command
//   mem_rdata                  memory read data (used on last mem_en cycle)

module mem_port_arbiter #(
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        R,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [63:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_mode,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [2:0]  mem_mode,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam int            CW                 = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT           = CW'(LATENCY - 1);
  localparam logic [2:0]    MODE_WORD_UNSIGNED = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_owner_d;   // 1 = data owns the access, 0 = fetch
  logic          r_flushed;   // fetch in flight was cancelled by a branch
  logic          r_if_rvalid;
  logic          r_d_rvalid;
  logic [63:0]   r_if_rdata;
  logic [63:0]   r_d_rdata;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [63:0]   r_mem_addr;
  logic [2:0]    r_mem_mode;
  logic [63:0]   r_mem_wdata;

  logic          w_grant_ok;
  logic          w_fetch_prio;
  logic          w_d_gnt;
  logic          w_if_gnt;

  // Grant decision: only from IDLE/RESP, never under reset.
  always_comb begin
    w_grant_ok = 1'b0;
    w_d_gnt    = 1'b0;
    w_if_gnt   = 1'b0;
    if (!R && (r_state == S_IDLE || r_state == S_RESP)) begin
      w_grant_ok = 1'b1;
    end else begin
      w_grant_ok = 1'b0;
    end
    w_d_gnt  = w_grant_ok && d_req && !w_fetch_prio;
    w_if_gnt = w_grant_ok && if_req && !w_d_gnt;
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve_cnt;

  // fetch_prio only asserts when fetch is actually waiting
  assign w_fetch_prio = if_req && (r_starve_cnt >= SW'(STARVE_LIMIT));

  // Count data grants made while fetch is waiting.
  always_ff @(posedge clk) begin
    if (R) begin
      r_starve_cnt <= '0;
    end else if (!if_req || w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (w_d_gnt && (r_starve_cnt < SW'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`else
  // Strict data priority; the comparison is constant false.
  assign w_fetch_prio = (STARVE_LIMIT < 0);
`endif

  // Access sequencer: capture winner, drive memory, return response.
  always_ff @(posedge clk) begin
    if (R) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner_d   <= 1'b0;
      r_flushed   <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= 64'd0;
      r_d_rdata   <= 64'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 64'd0;
      r_mem_mode  <= 3'd0;
      r_mem_wdata <= 64'd0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      if (w_d_gnt || w_if_gnt) begin
        r_state   <= S_ACCESS;
        r_cnt     <= CNT_INIT;
        r_owner_d <= w_d_gnt;
        r_flushed <= 1'b0;
        r_mem_en  <= 1'b1;
        if (w_d_gnt) begin
          r_mem_we    <= d_we;
          r_mem_addr  <= d_addr;
          r_mem_mode  <= d_mode;
          r_mem_wdata <= d_wdata;
        end else begin
          r_mem_we    <= 1'b0;
          r_mem_addr  <= if_addr;
          r_mem_mode  <= MODE_WORD_UNSIGNED;
          r_mem_wdata <= 64'd0;
        end
      end else begin
        case (r_state)
          S_ACCESS: begin
            if (!r_owner_d && if_flush) begin
              r_flushed <= 1'b1;
            end else begin
              r_flushed <= r_flushed;
            end
            if (r_cnt == '0) begin
              // Last memory cycle: mem_rdata is valid now.
              r_state  <= S_RESP;
              r_mem_en <= 1'b0;
              r_mem_we <= 1'b0;
              if (r_owner_d) begin
                r_d_rvalid <= 1'b1;
                r_d_rdata  <= r_mem_we ? 64'd0 : mem_rdata;
              end else begin
                r_if_rvalid <= !(r_flushed || if_flush);
                r_if_rdata  <= mem_rdata;
              end
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          S_RESP:  r_state <= S_IDLE;
          S_IDLE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  // A branch in the response cycle still cancels the fetch response.
  assign if_rvalid = r_if_rvalid & ~if_flush;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_mode  = r_mem_mode;
  assign mem_wdata = r_mem_wdata;

endmodule
